// File: rtl/hwpe_stream_tcdm_load_source_sidech_pkg.sv
// Shared types for the strided TCDM load source with side channel.
// The optional checker is enabled by HWPE_STREAM_LOAD_SOURCE_CHECK_EN.
package hwpe_stream_tcdm_load_source_sidech_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } load_source_state_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [31:0] length;
  } ctrl_load_source_t;

  localparam logic [3:0] LOAD_SOURCE_BE_ALL = 4'hF;

endpackage

// File: rtl/hwpe_stream_credit_counter.sv
// Up/down credit counter bounded to [0, MAX_CREDIT].
// Simultaneous inc/dec leaves the count unchanged.
module hwpe_stream_credit_counter #(
  parameter int unsigned MAX_CREDIT = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_CREDIT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_inc;
  logic                 w_dec;

  assign w_inc = inc_i && (r_cnt < CNT_WIDTH'(MAX_CREDIT));
  assign w_dec = dec_i && (r_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hwpe_stream_tcdm_load_source_sidech.sv
// Strided word-read request source with {last, idx} side channel tags.
// Define HWPE_STREAM_LOAD_SOURCE_CHECK_EN to add err_o and assertions.
module hwpe_stream_tcdm_load_source_sidech
  import hwpe_stream_tcdm_load_source_sidech_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned IDX_WIDTH       = 4,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [LEN_WIDTH-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 tcdm_r_ready_o,
  output logic [IDX_WIDTH:0]   sidech_o,
  input  logic [IDX_WIDTH:0]   sidech_i,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o,
  output logic                 stream_last_o
`ifdef HWPE_STREAM_LOAD_SOURCE_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  load_source_state_t   r_state;
  load_source_state_t   w_state_nxt;
  ctrl_load_source_t    w_ctrl;
  logic [31:0]          r_addr;
  logic [31:0]          r_stride;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_issue_cnt;
  logic [LEN_WIDTH-1:0] r_recv_cnt;
  logic [LEN_WIDTH-1:0] w_recv_nxt;
  logic [CW-1:0]        w_credit;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_start;
  logic                 w_len_nz;
  logic                 w_req;
  logic                 w_gnt;
  logic                 w_pop;
  logic                 w_last_req;

  assign w_ctrl.base_addr = base_addr_i;
  assign w_ctrl.stride    = stride_i;
  assign w_ctrl.length    = 32'(length_i);

  assign w_len_nz   = (w_ctrl.length != '0);
  assign w_start    = (r_state == IDLE) && start_i;
  assign w_req      = (r_state == ISSUE) &&
                      (w_credit < CW'(MAX_OUTSTANDING));
  assign w_gnt      = w_req && tcdm_gnt_i;
  // pops outside a transfer are passed through but never counted
  assign w_pop      = tcdm_r_valid_i && stream_ready_i &&
                      (r_state != IDLE);
  assign w_last_req = (r_issue_cnt == r_len - LEN_WIDTH'(1));
  assign w_recv_nxt = r_recv_cnt + LEN_WIDTH'(w_pop);

  hwpe_stream_credit_counter #(
    .MAX_CREDIT (MAX_OUTSTANDING),
    .CNT_WIDTH  (CW)
  ) i_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i || w_start),
    .inc_i   (w_gnt),
    .dec_i   (w_pop),
    .cnt_o   (w_credit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          if (w_len_nz) w_state_nxt = ISSUE;
          else          w_done_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        if (w_gnt && w_last_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_recv_nxt == r_len) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start && w_len_nz) begin
        r_addr      <= w_ctrl.base_addr;
        r_stride    <= w_ctrl.stride;
        r_len       <= w_ctrl.length[LEN_WIDTH-1:0];
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (w_gnt) begin
          r_addr      <= r_addr + r_stride;
          r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
        end
        if (w_pop) r_recv_cnt <= w_recv_nxt;
      end
    end
  end

  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = r_addr;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = LOAD_SOURCE_BE_ALL;
  assign tcdm_data_o    = '0;
  assign sidech_o       = {w_last_req, r_issue_cnt[IDX_WIDTH-1:0]};
  assign tcdm_r_ready_o = stream_ready_i;
  assign stream_valid_o = tcdm_r_valid_i;
  assign stream_data_o  = tcdm_r_data_i;
  assign stream_strb_o  = LOAD_SOURCE_BE_ALL;
  assign stream_last_o  = sidech_i[IDX_WIDTH];

`ifdef HWPE_STREAM_LOAD_SOURCE_CHECK_EN
  logic r_err;
  logic w_bad_pop;

  assign w_bad_pop = w_pop &&
    ((sidech_i[IDX_WIDTH-1:0] != r_recv_cnt[IDX_WIDTH-1:0]) ||
     (w_credit == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || w_start) r_err <= 1'b0;
    else if (w_bad_pop)              r_err <= 1'b1;
  end

  assign err_o = r_err;

`ifndef SYNTHESIS
  a_credit_max: assert property (@(posedge clk_i) disable iff (rst_i)
    w_credit <= CW'(MAX_OUTSTANDING));

  a_req_stable: assert property (@(posedge clk_i)
    disable iff (rst_i || clear_i)
    (tcdm_req_o && !tcdm_gnt_i) |=>
      ($stable(tcdm_add_o) && $stable(sidech_o)));
`endif
`else
  logic w_unused_idx;
  assign w_unused_idx = ^sidech_i[IDX_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_source_sidech.sv
// Bench for the strided load source: table vectors, corner sequences
// and random transfers against a counting reference model.
module tb_hwpe_stream_tcdm_load_source_sidech;

  localparam int MAXO = 8;
  localparam int IDXW = 4;
  localparam int LENW = 16;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [31:0]     base_addr_i = '0;
  logic [31:0]     stride_i = '0;
  logic [LENW-1:0] length_i = '0;
  logic            busy_o, done_o;
  logic            tcdm_req_o;
  logic            tcdm_gnt_i = 1'b0;
  logic [31:0]     tcdm_add_o;
  logic            tcdm_wen_o;
  logic [3:0]      tcdm_be_o;
  logic [31:0]     tcdm_data_o;
  logic [31:0]     tcdm_r_data_i = '0;
  logic            tcdm_r_valid_i = 1'b0;
  logic            tcdm_r_ready_o;
  logic [IDXW:0]   sidech_o;
  logic [IDXW:0]   sidech_i = '0;
  logic            stream_valid_o;
  logic            stream_ready_i = 1'b0;
  logic [31:0]     stream_data_o;
  logic [3:0]      stream_strb_o;
  logic            stream_last_o;
`ifdef HWPE_STREAM_LOAD_SOURCE_CHECK_EN
  logic            err_o;
`endif

  always #5 clk = ~clk;

  hwpe_stream_tcdm_load_source_sidech #(
    .MAX_OUTSTANDING (MAXO),
    .IDX_WIDTH       (IDXW),
    .LEN_WIDTH       (LENW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .stride_i       (stride_i),
    .length_i       (length_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .tcdm_r_ready_o (tcdm_r_ready_o),
    .sidech_o       (sidech_o),
    .sidech_i       (sidech_i),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .stream_data_o  (stream_data_o),
    .stream_strb_o  (stream_strb_o),
    .stream_last_o  (stream_last_o)
`ifdef HWPE_STREAM_LOAD_SOURCE_CHECK_EN
    ,
    .err_o          (err_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0]   data;
    logic [IDXW:0] sc;
  } rsp_t;
  rsp_t env_q[$];

  int gnt_pct = 100;
  int rdy_pct = 100;
  bit corrupt = 1'b0;

  // reference model: transfer progress in plain counts
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_base, m_stride;
  int          m_len, m_granted, m_popped;

  int          s_grants, s_beats, s_peak, s_done, s_reqs, s_stall;
  logic [31:0] s_last_addr;
  bit          p_stall = 1'b0;
  logic [31:0] p_add;
  logic [IDXW:0] p_sc;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    int          len;
    int          gnt_pct;
    int          rdy_pct;
    logic [31:0] exp_last;
    int          exp_beats;
  } vec_t;
  vec_t vec[7];

  function automatic logic [31:0] dfn(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic observe();
    logic          exp_req, g, p, act_pre;
    logic [IDXW:0] es;
    logic [31:0]   ea;
    rsp_t          r;
    act_pre = m_active;
    exp_req = m_active && (m_granted < m_len) &&
              ((m_granted - m_popped) < MAXO);
    chk("req", tcdm_req_o, exp_req);
    chk("busy", busy_o, m_active);
    chk("done", done_o, m_done);
    chk("svalid", stream_valid_o, tcdm_r_valid_i);
    chk("rready", tcdm_r_ready_o, stream_ready_i);
    if (tcdm_r_valid_i) begin
      chk("sdata", stream_data_o, tcdm_r_data_i);
      chk("slast", stream_last_o, sidech_i[IDXW]);
      chk("sstrb", stream_strb_o, 4'hF);
    end
    if (p_stall) begin
      chk("stall_add", tcdm_add_o, p_add);
      chk("stall_sc", sidech_o, p_sc);
    end
    if (exp_req) begin
      ea = m_base + m_stride * 32'(m_granted);
      es = {(m_granted == m_len - 1), 4'(m_granted)};
      chk("add", tcdm_add_o, ea);
      chk("sidech", sidech_o, 32'(es));
    end
    g = tcdm_req_o && tcdm_gnt_i;
    p = tcdm_r_valid_i && stream_ready_i;
    p_stall = tcdm_req_o && !tcdm_gnt_i;
    p_add = tcdm_add_o;
    p_sc = sidech_o;
    if (p_stall) s_stall++;
    if (done_o) s_done++;
    if (tcdm_req_o) s_reqs++;
    m_done = 1'b0;
    if (p && env_q.size() > 0) begin
      env_q.delete(0);
      if (act_pre) begin
        ea = m_base + m_stride * 32'(m_popped);
        chk("beat_data", stream_data_o, dfn(ea));
        chk("beat_last", stream_last_o, m_popped == m_len - 1);
        m_popped++;
        s_beats++;
        if (m_popped == m_len) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    if (g) begin
      r.data = dfn(tcdm_add_o);
      r.sc = sidech_o;
      env_q.push_back(r);
      s_grants++;
      s_last_addr = tcdm_add_o;
      if (act_pre) m_granted++;
    end
    if (m_active && (m_granted - m_popped) > s_peak)
      s_peak = m_granted - m_popped;
    if (start_i && !act_pre) begin
      if (length_i != '0) begin
        m_active = 1'b1;
        m_base = base_addr_i;
        m_stride = stride_i;
        m_len = int'(length_i);
        m_granted = 0;
        m_popped = 0;
      end else begin
        m_done = 1'b1;
      end
    end
    if (rst_i || clear_i) begin
      m_active = 1'b0;
      m_done = 1'b0;
      p_stall = 1'b0;
      env_q.delete();
    end
  endtask

  task automatic drive();
    tcdm_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    stream_ready_i = (int'($urandom_range(0, 99)) < rdy_pct);
    tcdm_r_valid_i = (env_q.size() > 0);
    if (env_q.size() > 0) begin
      tcdm_r_data_i = env_q[0].data;
      sidech_i = env_q[0].sc;
      if (corrupt && env_q[0].sc[IDXW-1:0] == 4'd1)
        sidech_i[IDXW-1:0] = 4'd2;
    end else begin
      tcdm_r_data_i = $urandom;
      sidech_i = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic launch(input logic [31:0] b, input logic [31:0] s,
                        input int l);
    base_addr_i = b;
    stride_i = s;
    length_i = LENW'(l);
    start_i = 1'b1;
    s_grants = 0; s_beats = 0; s_peak = 0;
    s_done = 0; s_reqs = 0; s_stall = 0;
    s_last_addr = 32'hDEAD_BEEF;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int c = 0;
    while ((m_active || m_done) && c < budget) begin
      tick();
      c++;
    end
    chk({nm, "_timeout"}, 32'(c < budget), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    vec[0] = '{32'h1000, 32'd4, 5, 100, 100, 32'h1010, 5};
    vec[1] = '{32'h4, 32'hFFFF_FFFC, 3, 100, 100, 32'hFFFF_FFFC, 3};
    vec[2] = '{32'h100, 32'h10, 1, 100, 100, 32'h100, 1};
    vec[3] = '{32'hFFFF_FFF0, 32'd8, 4, 100, 100, 32'h8, 4};
    vec[4] = '{32'h0, 32'd0, 3, 70, 70, 32'h0, 3};
    vec[5] = '{32'h8000, 32'h100, 17, 60, 50, 32'h9000, 17};
    vec[6] = '{32'h2000, 32'h20, 20, 100, 100, 32'h2260, 20};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_req", tcdm_req_o, 1'b0);
    chk("rst_add", tcdm_add_o, 32'h0);
    chk("rst_wen", tcdm_wen_o, 1'b1);
    chk("rst_be", tcdm_be_o, 4'hF);
    chk("rst_wdata", tcdm_data_o, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      gnt_pct = vec[i].gnt_pct;
      rdy_pct = vec[i].rdy_pct;
      launch(vec[i].base, vec[i].stride, vec[i].len);
      wait_idle("vec", 2000);
      chk("vec_beats", s_beats, vec[i].exp_beats);
      chk("vec_last_addr", s_last_addr, vec[i].exp_last);
      chk("vec_done_cnt", s_done, 1);
    end

    // credit limit: no pops, so at most MAXO grants
    gnt_pct = 100; rdy_pct = 0;
    tick();
    launch(32'h3000, 32'd4, 20);
    repeat (30) tick();
    chk("credit_grants", s_grants, MAXO);
    chk("credit_req_low", tcdm_req_o, 1'b0);
    rdy_pct = 100;
    wait_idle("credit", 500);
    chk("credit_beats", s_beats, 20);
    chk("credit_peak", s_peak, MAXO);
    chk("credit_done", s_done, 1);

    // grant withheld for 5 cycles mid-transfer
    gnt_pct = 100; rdy_pct = 100;
    launch(32'h5000, 32'd12, 10);
    repeat (3) tick();
    gnt_pct = 0;
    repeat (5) tick();
    gnt_pct = 100;
    wait_idle("bp", 200);
    chk("bp_stall", s_stall, 5);
    chk("bp_beats", s_beats, 10);
    chk("bp_last_addr", s_last_addr, 32'h506C);
    chk("bp_done", s_done, 1);

    launch(32'h700, 32'd4, 0);
    wait_idle("zero", 20);
    chk("zero_reqs", s_reqs, 0);
    chk("zero_done", s_done, 1);

    // clear with three requests outstanding
    gnt_pct = 100; rdy_pct = 0;
    tick();
    launch(32'h6000, 32'd4, 10);
    repeat (2) tick();
    gnt_pct = 0;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", busy_o, 1'b0);
    chk("clr_req", tcdm_req_o, 1'b0);
    chk("clr_add", tcdm_add_o, 32'h0);
    chk("clr_grants", s_grants, 3);
    gnt_pct = 100; rdy_pct = 100;
    repeat (4) tick();
    chk("clr_no_done", s_done, 0);

    for (int i = 0; i < 15; i++) begin
      int l;
      logic [31:0] s;
      l = int'($urandom_range(1, 40));
      s = 32'($urandom_range(0, 16)) * 32'd4 - 32'd32;
      gnt_pct = int'($urandom_range(30, 100));
      rdy_pct = int'($urandom_range(20, 100));
      launch($urandom, s, l);
      wait_idle("rnd", 4000);
      chk("rnd_beats", s_beats, l);
      chk("rnd_done", s_done, 1);
    end

`ifdef HWPE_STREAM_LOAD_SOURCE_CHECK_EN
    gnt_pct = 100; rdy_pct = 100;
    chk("err_init", err_o, 1'b0);
    corrupt = 1'b1;
    launch(32'h9000, 32'd4, 4);
    wait_idle("err", 200);
    corrupt = 1'b0;
    chk("err_set", err_o, 1'b1);
    repeat (3) tick();
    chk("err_sticky", err_o, 1'b1);
    launch(32'hA000, 32'd4, 2);
    chk("err_clr", err_o, 1'b0);
    wait_idle("err2", 200);
    chk("err_stay_clr", err_o, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
